crc_frame_checker: RTL and testbench

- Receive-side counterpart of the parallel CRC generator.
- Consumes a framed word stream, runs the same parameterised CRC over every payload beat, and compares the result against the CRC carried in the frame's final beat.
- Reports a per-frame pass/fail pulse, the payload length and a saturating error count.
- Sits at the ingress of any link whose transmitter appends the generator's CRC output.

---
 rtl/crc_frame_checker.sv | 163 ++++++++++++++++
 tb/tb_crc_frame_checker.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/crc_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : crc_frame_checker
// Brief    : Checks the CRC carried in the final beat of each frame.
// Revision : 1.0
// ============================================================================
module crc_frame_checker #(
   parameter                          POLY       = 8'h07,
   parameter logic [$bits(POLY)-1:0]  INIT       = 8'h00,
   parameter bit                      REFLECT    = 1'b0,
   parameter logic [$bits(POLY)-1:0]  XOR_OUT    = 8'h00,
   parameter int                      DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [DATA_WIDTH-1:0]   data_i,
   input  logic                    data_valid_i,
   input  logic                    last_i,
   input  logic                    abort_i,
   output logic                    busy_o,
   output logic                    done_o,
   output logic                    crc_ok_o,
   output logic                    crc_err_o,
   output logic [$bits(POLY)-1:0]  crc_calc_o,
   output logic [15:0]             frame_len_o,
   output logic [15:0]             err_count_o
);

   localparam int CW      = $bits(POLY);
   localparam int NB_DATA = DATA_WIDTH / 8;
   localparam int NB_CRC  = CW / 8;

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic                    w_accept;
   logic                    w_complete;

   logic [CW-1:0]           r_crc;
   logic [15:0]             r_len;
   logic [CW-1:0]           w_crc_base;
   logic [15:0]             w_len_base;
   logic [15:0]             w_len_inc;
   logic [CW-1:0]           w_crc_next;
   logic [DATA_WIDTH-1:0]   w_beat_refl;
   logic [DATA_WIDTH-1:0]   w_beat;
   logic [CW-1:0]           w_crc_refl;
   logic [CW-1:0]           w_crc_map;
   logic                    w_match;

   logic                    r_done;
   logic                    r_ok;
   logic                    r_err;
   logic [CW-1:0]           r_calc;
   logic [15:0]             r_len_out;
   logic [15:0]             r_err_cnt;

   // Per-byte bit reversal of the beat; the CRC mapping reverses bits per byte and swaps bytes.
   for (genvar gb = 0; gb < NB_DATA; gb++) begin : g_beat_byte
      for (genvar gi = 0; gi < 8; gi++) begin : g_beat_bit
         assign w_beat_refl[gb*8+gi] = data_i[gb*8+7-gi];
      end
   end

   for (genvar gb = 0; gb < NB_CRC; gb++) begin : g_crc_byte
      for (genvar gi = 0; gi < 8; gi++) begin : g_crc_bit
         assign w_crc_refl[gb*8+gi] = w_crc_base[(NB_CRC-1-gb)*8+7-gi];
      end
   end

   // Out of a frame the running value is taken as INIT, so a new frame can start any cycle.
   assign w_crc_base = (r_state == S_IDLE) ? INIT  : r_crc;
   assign w_len_base = (r_state == S_IDLE) ? 16'd0 : r_len;
   assign w_len_inc  = (w_len_base == 16'hFFFF) ? w_len_base : w_len_base + 16'd1;
   assign w_beat     = REFLECT ? w_beat_refl : data_i;
   assign w_crc_map  = (REFLECT ? w_crc_refl : w_crc_base) ^ XOR_OUT;
   assign w_match    = (w_crc_map == data_i[CW-1:0]);

   always_comb begin
      logic fb;
      w_crc_next = w_crc_base;
      fb         = 1'b0;
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
         fb         = w_crc_next[CW-1] ^ w_beat[i];
         w_crc_next = {w_crc_next[CW-2:0], 1'b0} ^ ({CW{fb}} & POLY);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Abort wins over a beat presented in the same cycle.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_complete   = 1'b0;
      if (abort_i) begin
         w_state_next = S_IDLE;
      end else if (data_valid_i) begin
         if (last_i) begin
            w_complete   = 1'b1;
            w_state_next = S_IDLE;
         end else begin
            w_accept     = 1'b1;
            w_state_next = S_ACTIVE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_crc <= INIT;
         r_len <= 16'd0;
      end else if (w_accept) begin
         r_crc <= w_crc_next;
         r_len <= w_len_inc;
      end else if (abort_i || w_complete) begin
         r_crc <= INIT;
         r_len <= 16'd0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_done    <= 1'b0;
         r_ok      <= 1'b0;
         r_err     <= 1'b0;
         r_calc    <= '0;
         r_len_out <= 16'd0;
         r_err_cnt <= 16'd0;
      end else begin
         r_done <= w_complete;
         if (w_complete) begin
            r_ok      <= w_match;
            r_err     <= ~w_match;
            r_calc    <= w_crc_map;
            r_len_out <= w_len_base;
            if (!w_match && (r_err_cnt != 16'hFFFF)) begin
               r_err_cnt <= r_err_cnt + 16'd1;
            end
         end
      end
   end

   assign busy_o      = (r_state == S_ACTIVE);
   assign done_o      = r_done;
   assign crc_ok_o    = r_ok;
   assign crc_err_o   = r_err;
   assign crc_calc_o  = r_calc;
   assign frame_len_o = r_len_out;
   assign err_count_o = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_crc_frame_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_crc_frame_checker
// Brief    : Directed self-checking bench for crc_frame_checker.
// Revision : 1.0
// ============================================================================
module tb_crc_frame_checker;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  data = 8'h00;
   logic        valid = 1'b0;
   logic        last = 1'b0;
   logic        abort = 1'b0;

   logic        busy0, done0, ok0, err0;
   logic [7:0]  calc0;
   logic [15:0] len0, ecnt0;
   logic        busy1, done1, ok1, err1;
   logic [7:0]  calc1;
   logic [15:0] len1, ecnt1;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0] msg [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

   always #5 clk = ~clk;

   crc_frame_checker dut0 (
      .clk(clk), .reset_n(reset_n), .data_i(data), .data_valid_i(valid),
      .last_i(last), .abort_i(abort), .busy_o(busy0), .done_o(done0),
      .crc_ok_o(ok0), .crc_err_o(err0), .crc_calc_o(calc0),
      .frame_len_o(len0), .err_count_o(ecnt0)
   );

   crc_frame_checker #(.POLY(8'h31), .REFLECT(1'b1)) dut1 (
      .clk(clk), .reset_n(reset_n), .data_i(data), .data_valid_i(valid),
      .last_i(last), .abort_i(abort), .busy_o(busy1), .done_o(done1),
      .crc_ok_o(ok1), .crc_err_o(err1), .crc_calc_o(calc1),
      .frame_len_o(len1), .err_count_o(ecnt1)
   );

   // One cycle of stimulus; returns 1 time unit after the consuming edge.
   task automatic drive(input logic [7:0] d, input logic v, input logic l, input logic a);
      data  = d;
      valid = v;
      last  = l;
      abort = a;
      @(posedge clk);
      #1;
      valid = 1'b0;
      last  = 1'b0;
      abort = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++; if (busy0 !== 1'b0)  begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy0); end
      tests_run++; if (done0 !== 1'b0)  begin tests_failed++; $display("FAIL reset_done got=%b exp=0", done0); end
      tests_run++; if ({ok0, err0} !== 2'b00) begin tests_failed++; $display("FAIL reset_okerr got=%b exp=00", {ok0, err0}); end
      tests_run++; if (calc0 !== 8'h00) begin tests_failed++; $display("FAIL reset_calc got=%h exp=00", calc0); end
      tests_run++; if (len0 !== 16'h0 || ecnt0 !== 16'h0) begin tests_failed++; $display("FAIL reset_counts len=%h ecnt=%h exp=0", len0, ecnt0); end
      reset_n = 1'b1;
      drive(8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_good_frame();
      drive(msg[0], 1'b1, 1'b0, 1'b0);
      tests_run++; if (busy0 !== 1'b1) begin tests_failed++; $display("FAIL good_busy_rise got=%b exp=1", busy0); end
      for (int i = 1; i < 9; i++) drive(msg[i], 1'b1, 1'b0, 1'b0);
      tests_run++; if (done0 !== 1'b0) begin tests_failed++; $display("FAIL good_early_done got=%b exp=0", done0); end
      drive(8'hF4, 1'b1, 1'b1, 1'b0);
      tests_run++; if (done0 !== 1'b1) begin tests_failed++; $display("FAIL good_done got=%b exp=1", done0); end
      tests_run++; if ({ok0, err0} !== 2'b10) begin tests_failed++; $display("FAIL good_okerr got=%b exp=10", {ok0, err0}); end
      tests_run++; if (calc0 !== 8'hF4) begin tests_failed++; $display("FAIL good_calc got=%h exp=f4", calc0); end
      tests_run++; if (len0 !== 16'd9) begin tests_failed++; $display("FAIL good_len got=%0d exp=9", len0); end
      tests_run++; if (ecnt0 !== 16'd0) begin tests_failed++; $display("FAIL good_ecnt got=%0d exp=0", ecnt0); end
      tests_run++; if (busy0 !== 1'b0) begin tests_failed++; $display("FAIL good_busy_fall got=%b exp=0", busy0); end
      drive(8'h00, 1'b0, 1'b0, 1'b0);
      tests_run++; if (done0 !== 1'b0 || ok0 !== 1'b1) begin tests_failed++; $display("FAIL good_hold done=%b ok=%b exp done=0 ok=1", done0, ok0); end
   endtask

   task automatic test_bad_frame();
      for (int i = 0; i < 9; i++) drive(msg[i], 1'b1, 1'b0, 1'b0);
      drive(8'hF5, 1'b1, 1'b1, 1'b0);
      tests_run++; if ({done0, ok0, err0} !== 3'b101) begin tests_failed++; $display("FAIL bad_flags got=%b exp=101", {done0, ok0, err0}); end
      tests_run++; if (calc0 !== 8'hF4) begin tests_failed++; $display("FAIL bad_calc got=%h exp=f4", calc0); end
      tests_run++; if (ecnt0 !== 16'd1) begin tests_failed++; $display("FAIL bad_ecnt got=%0d exp=1", ecnt0); end
   endtask

   task automatic test_empty_frame();
      drive(8'h00, 1'b1, 1'b1, 1'b0);
      tests_run++; if (busy0 !== 1'b0) begin tests_failed++; $display("FAIL empty_busy got=%b exp=0", busy0); end
      tests_run++; if ({done0, ok0, err0} !== 3'b110) begin tests_failed++; $display("FAIL empty_flags got=%b exp=110", {done0, ok0, err0}); end
      tests_run++; if (len0 !== 16'd0 || calc0 !== 8'h00) begin tests_failed++; $display("FAIL empty_len_calc len=%0d calc=%h exp 0/00", len0, calc0); end
      tests_run++; if (ecnt0 !== 16'd1) begin tests_failed++; $display("FAIL empty_ecnt got=%0d exp=1", ecnt0); end
   endtask

   task automatic test_abort();
      int dones;
      for (int i = 0; i < 3; i++) drive(msg[i], 1'b1, 1'b0, 1'b0);
      drive(msg[3], 1'b1, 1'b0, 1'b1);
      tests_run++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin tests_failed++; $display("FAIL abort_state busy=%b done=%b exp 0/0", busy0, done0); end
      tests_run++; if (len0 !== 16'd0 || ok0 !== 1'b1) begin tests_failed++; $display("FAIL abort_held len=%0d ok=%b exp 0/1", len0, ok0); end
      dones = 0;
      for (int i = 0; i < 9; i++) begin
         drive(msg[i], 1'b1, 1'b0, 1'b0);
         dones += int'(done0);
      end
      drive(8'hF4, 1'b1, 1'b1, 1'b0);
      dones += int'(done0);
      tests_run++; if ({ok0, len0} !== {1'b1, 16'd9}) begin tests_failed++; $display("FAIL abort_frame ok=%b len=%0d exp 1/9", ok0, len0); end
      for (int i = 0; i < 2; i++) begin
         drive(8'h00, 1'b0, 1'b0, 1'b0);
         dones += int'(done0);
      end
      tests_run++; if (dones !== 1) begin tests_failed++; $display("FAIL abort_done_count got=%0d exp=1", dones); end
   endtask

   task automatic test_back_to_back();
      int dones;
      dones = 0;
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < 9; i++) begin
            drive(msg[i], 1'b1, 1'b0, 1'b0);
            dones += int'(done0);
         end
         drive(8'hF4, 1'b1, 1'b1, 1'b0);
         dones += int'(done0);
         tests_run++; if ({done0, ok0, len0} !== {2'b11, 16'd9}) begin tests_failed++; $display("FAIL b2b_frame%0d done=%b ok=%b len=%0d exp 1/1/9", f, done0, ok0, len0); end
      end
      drive(8'h00, 1'b0, 1'b0, 1'b0);
      dones += int'(done0);
      tests_run++; if (dones !== 2) begin tests_failed++; $display("FAIL b2b_done_count got=%0d exp=2", dones); end
      tests_run++; if (ecnt0 !== 16'd1) begin tests_failed++; $display("FAIL b2b_ecnt got=%0d exp=1", ecnt0); end
   endtask

   task automatic test_maxim();
      for (int i = 0; i < 9; i++) drive(msg[i], 1'b1, 1'b0, 1'b0);
      drive(8'hA1, 1'b1, 1'b1, 1'b0);
      tests_run++; if ({done1, ok1, err1} !== 3'b110) begin tests_failed++; $display("FAIL maxim_flags got=%b exp=110", {done1, ok1, err1}); end
      tests_run++; if (calc1 !== 8'hA1 || len1 !== 16'd9) begin tests_failed++; $display("FAIL maxim_calc_len calc=%h len=%0d exp a1/9", calc1, len1); end
      tests_run++; if (ecnt0 !== 16'd2) begin tests_failed++; $display("FAIL maxim_crc8_ecnt got=%0d exp=2", ecnt0); end
   endtask

   task automatic test_reset_midframe();
      int dones;
      for (int i = 0; i < 3; i++) drive(msg[i], 1'b1, 1'b0, 1'b0);
      #2 reset_n = 1'b0;
      #1;
      tests_run++; if ({busy0, ok0, ecnt0} !== {2'b00, 16'd0}) begin tests_failed++; $display("FAIL midreset_async busy=%b ok=%b ecnt=%0d exp 0/0/0", busy0, ok0, ecnt0); end
      @(posedge clk);
      #1 reset_n = 1'b1;
      dones = 0;
      for (int i = 0; i < 3; i++) begin
         drive(8'h00, 1'b0, 1'b0, 1'b0);
         dones += int'(done0);
      end
      tests_run++; if (dones !== 0 || busy0 !== 1'b0) begin tests_failed++; $display("FAIL midreset_nodone dones=%0d busy=%b exp 0/0", dones, busy0); end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 65534; i++) drive(8'h01, 1'b1, 1'b1, 1'b0);
      tests_run++; if (ecnt0 !== 16'hFFFE) begin tests_failed++; $display("FAIL sat_pre got=%h exp=fffe", ecnt0); end
      tests_run++; if ({ok0, err0} !== 2'b01) begin tests_failed++; $display("FAIL sat_flags got=%b exp=01", {ok0, err0}); end
      for (int i = 0; i < 2; i++) drive(8'h01, 1'b1, 1'b1, 1'b0);
      tests_run++; if (ecnt0 !== 16'hFFFF) begin tests_failed++; $display("FAIL sat_final got=%h exp=ffff", ecnt0); end
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_good_frame();
      test_bad_frame();
      test_empty_frame();
      test_abort();
      test_back_to_back();
      test_maxim();
      test_reset_midframe();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
